// File: rtl/seg_display_if.sv
// Bus between the processor core and the 7-segment display stage.
// The core side is the master; the display stage is the slave.
interface seg_display_if;
   logic        load;
   logic [31:0] value;
   logic        blank_lz;
   logic        busy;
   logic [63:0] seg_out;
   logic [7:0]  seg_sel;

   modport master (
      output load, value, blank_lz,
      input  busy, seg_out, seg_sel
   );

   modport slave (
      input  load, value, blank_lz,
      output busy, seg_out, seg_sel
   );
endinterface

// File: rtl/seg_display.sv
// Captures a 32-bit word, encodes it one nibble per cycle into a shadow buffer,
// commits all eight digits to seg_out at once, and scans a one-hot digit select.
//
// state    | meaning
// S_IDLE   | waiting for load; accepts value/blank_lz into shadow registers
// S_ENC    | encoding digit r_idx (7 down to 0) into the shadow buffer
// S_COMMIT | copying the shadow buffer to seg_out in a single edge
module seg_display #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic          clk,
   input  logic          n_rst,
   seg_display_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENC    = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_value, w_value_nxt;
   logic        r_blank_lz, w_blank_lz_nxt;
   logic [2:0]  r_idx, w_idx_nxt;
   logic        r_zero_run, w_zero_run_nxt;
   logic [63:0] r_shadow, w_shadow_nxt;
   logic [63:0] r_seg_out, w_seg_out_nxt;
   logic [15:0] r_scan_cnt;
   logic [7:0]  r_seg_sel;

   logic [3:0]  w_nib;
   logic        w_blank_dig;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      logic [7:0] seg;
      case (n)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         default: seg = 8'h71;
      endcase
      return seg;
   endfunction

   assign w_nib = r_value[{r_idx, 2'b00} +: 4];

   // Digit 0 is never blanked so an all-zero word still shows "0".
   assign w_blank_dig = r_blank_lz && (w_nib == 4'h0) && r_zero_run && (r_idx != 3'd0);

   always_comb begin
      w_state_nxt    = r_state;
      w_value_nxt    = r_value;
      w_blank_lz_nxt = r_blank_lz;
      w_idx_nxt      = r_idx;
      w_zero_run_nxt = r_zero_run;
      w_shadow_nxt   = r_shadow;
      w_seg_out_nxt  = r_seg_out;
      unique case (r_state)
         S_IDLE: begin
            if (bus.load) begin
               w_value_nxt    = bus.value;
               w_blank_lz_nxt = bus.blank_lz;
               w_idx_nxt      = 3'd7;
               w_zero_run_nxt = 1'b1;
               w_state_nxt    = S_ENC;
            end
         end
         S_ENC: begin
            w_shadow_nxt[{r_idx, 3'b000} +: 8] = w_blank_dig ? 8'h00 : hex7(w_nib);
            if (w_nib != 4'h0) begin
               w_zero_run_nxt = 1'b0;
            end
            if (r_idx == 3'd0) begin
               w_state_nxt = S_COMMIT;
            end else begin
               w_idx_nxt = r_idx - 3'd1;
            end
         end
         S_COMMIT: begin
            w_seg_out_nxt = r_shadow;
            w_state_nxt   = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= S_IDLE;
         r_value    <= 32'h0;
         r_blank_lz <= 1'b0;
         r_idx      <= 3'd0;
         r_zero_run <= 1'b0;
         r_shadow   <= 64'h0;
         r_seg_out  <= 64'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_value    <= w_value_nxt;
         r_blank_lz <= w_blank_lz_nxt;
         r_idx      <= w_idx_nxt;
         r_zero_run <= w_zero_run_nxt;
         r_shadow   <= w_shadow_nxt;
         r_seg_out  <= w_seg_out_nxt;
      end
   end

   // Digit scan runs free of the encoder so the display never flickers during a load.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_scan_cnt <= 16'h0;
         r_seg_sel  <= 8'h01;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= 16'h0;
         r_seg_sel  <= {r_seg_sel[6:0], r_seg_sel[7]};
      end else begin
         r_scan_cnt <= r_scan_cnt + 16'h1;
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.seg_out = r_seg_out;
   assign bus.seg_sel = r_seg_sel;

endmodule

// File: tb/tb_seg_display.sv
// Scoreboarded bench for seg_display: stimulus pushes expected displays, a monitor
// pops them when busy falls and checks seg_out, busy and seg_sel every cycle.
module tb_seg_display;

   localparam int SCAN_DIV = 3;
   localparam logic [7:0] SEG [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   seg_display_if bus ();

   seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] exp_q [$];
   logic [63:0] exp_disp = 64'h0;
   int last_acc = -100;
   int next_ok  = 0;
   int rel_edge = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Display contents derived from the word: digits above the most significant
   // nonzero nibble are dark when blanking is on; digit 0 is always lit.
   function automatic logic [63:0] ref_disp(input logic [31:0] v, input logic b);
      logic [63:0] d;
      int top;
      top = 0;
      for (int i = 0; i < 8; i++)
         if (v[4*i +: 4] != 4'h0) top = i;
      d = 64'h0;
      for (int i = 0; i < 8; i++)
         d[8*i +: 8] = (b && i > top) ? 8'h00 : SEG[v[4*i +: 4]];
      return d;
   endfunction

   // Monitor: sampled 1 time unit after each rising edge.
   initial begin
      logic prev_busy;
      logic [7:0] exp_sel;
      logic exp_busy;
      int k;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!n_rst) begin
            prev_busy = 1'b0;
            exp_sel   = 8'h01;
            exp_busy  = 1'b0;
         end else begin
            if (prev_busy && !bus.busy) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_commit: got seg_out %h required no commit", bus.seg_out);
               end else begin
                  exp_disp = exp_q.pop_front();
               end
            end
            prev_busy = bus.busy;
            k = edge_n - rel_edge;
            exp_sel  = 8'h01 << ((k / SCAN_DIV) % 8);
            exp_busy = (edge_n >= last_acc) && (edge_n <= last_acc + 8);
         end
         check("busy", 64'(bus.busy), 64'(exp_busy));
         check("seg_out", bus.seg_out, exp_disp);
         check("seg_sel", 64'(bus.seg_sel), 64'(exp_sel));
      end
   end

   task automatic drive_cycle(input logic ld, input logic [31:0] v, input logic b);
      @(negedge clk);
      bus.load     = ld;
      bus.value    = v;
      bus.blank_lz = b;
      if (ld && n_rst && (edge_n + 1 >= next_ok)) begin
         last_acc = edge_n + 1;
         next_ok  = edge_n + 11;
         exp_q.push_back(ref_disp(v, b));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, $urandom, 1'($urandom));
   endtask

   task automatic do_load(input logic [31:0] v, input logic b);
      while (edge_n + 1 < next_ok) idle(1);
      drive_cycle(1'b1, v, b);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      n_rst    = 1'b0;
      bus.load = 1'b0;
      exp_q.delete();
      exp_disp = 64'h0;
      last_acc = -100;
      next_ok  = 0;
      repeat (n) @(negedge clk);
      n_rst    = 1'b1;
      rel_edge = edge_n;
   endtask

   initial begin
      logic [31:0] v;
      int sh;
      bus.load     = 1'b0;
      bus.value    = 32'h0;
      bus.blank_lz = 1'b0;
      do_reset(3);
      idle(2);

      do_load(32'h1234ABCD, 1'b0);
      do_load(32'h00000F00, 1'b1);
      do_load(32'h00000000, 1'b1);
      do_load(32'h00000000, 1'b0);

      // Loads during ENC/COMMIT must be dropped, the one at t+10 taken.
      do_load(32'h11111111, 1'b0);
      idle(2);
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0);
      idle(5);
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0);
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0);
      idle(12);

      for (int i = 0; i < 300; i++) begin
         v  = $urandom;
         sh = $urandom_range(0, 8);
         v  = v >> (4 * sh);
         drive_cycle(1'($urandom_range(0, 2) == 0), v, 1'($urandom));
      end

      do_load(32'h12345678, 1'b0);
      do_load(32'h9ABCDEF0, 1'b0);
      idle(3);
      do_reset(3);
      idle(30);
      do_load(32'h000000A5, 1'b1);

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
      idle(3);
      check("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
